// File: rtl/handshake_rx.sv
// USB handshake packet receiver: waits for sync after arming, captures the PID,
// checks the EOP and reports ACK/NAK/STALL/NYET, a malformed packet, or a timeout.
module handshake_rx #(
  parameter int MIN_SYNC_ZEROS = 4,
  parameter int TIMEOUT_BITS   = 18
) (
  input  logic useClk,
  input  logic nReset,
  input  logic checkData,
  input  logic rxBit,
  input  logic rxSE0,
  input  logic expectHandshake,
  output logic gotACK,
  output logic gotNAK,
  output logic gotSTALL,
  output logic gotNYET,
  output logic pidError,
  output logic timeoutHS,
  output logic busyRx
);

  // state | meaning
  // IDLE  | not armed, waiting for expectHandshake
  // WAIT  | armed, counting strobes until the first sync zero
  // SYNC  | counting sync zeros until the terminating one
  // PID   | shifting in 8 PID bits, LSB first
  // EOP   | counting SE0 bit times of the end-of-packet
  // DONE  | single cycle: decode the captured PID

  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_BITS);
  localparam logic [3:0]    MIN_Z   = 4'(MIN_SYNC_ZEROS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SYNC, S_PID, S_EOP, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    R_NONE, R_ACK, R_NAK, R_STALL, R_NYET, R_ERR, R_TMO
  } res_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    zero_q, zero_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    se0_q, se0_d;
  logic [7:0]    pid_q, pid_d;
  logic [5:0]    pulse_q, pulse_d;
  res_t          res_d;

  always_ff @(posedge useClk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      zero_q  <= '0;
      bit_q   <= '0;
      se0_q   <= '0;
      pid_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      zero_q  <= zero_d;
      bit_q   <= bit_d;
      se0_q   <= se0_d;
      pid_q   <= pid_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    zero_d  = zero_q;
    bit_d   = bit_q;
    se0_d   = se0_q;
    pid_d   = pid_q;
    res_d   = R_NONE;
    case (state_q)
      S_IDLE: begin
        if (expectHandshake) begin
          state_d = S_WAIT;
          tmo_d   = '0;
          zero_d  = '0;
          bit_d   = '0;
          se0_d   = '0;
        end
      end
      S_WAIT: begin
        // expiry is checked before the strobe so a coincident strobe is dropped
        if (tmo_q == TMO_MAX) begin
          state_d = S_IDLE;
          res_d   = R_TMO;
        end else if (checkData) begin
          if (!rxBit && !rxSE0) begin
            zero_d  = zero_q + 4'd1;
            state_d = S_SYNC;
          end else if (tmo_q < TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_SYNC: begin
        if (checkData) begin
          if (rxSE0) begin
            state_d = S_WAIT;
            zero_d  = '0;
          end else if (!rxBit) begin
            if (zero_q != 4'hF) zero_d = zero_q + 4'd1;
          end else if (zero_q >= MIN_Z) begin
            state_d = S_PID;
            bit_d   = '0;
          end else begin
            state_d = S_WAIT;
            zero_d  = '0;
          end
        end
      end
      S_PID: begin
        if (checkData) begin
          if (rxSE0) begin
            state_d = S_IDLE;
            res_d   = R_ERR;
          end else begin
            pid_d[bit_q] = rxBit;
            bit_d        = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_EOP;
              se0_d   = '0;
            end
          end
        end
      end
      S_EOP: begin
        if (checkData) begin
          if (rxSE0) begin
            if (se0_q == 2'd3) begin
              state_d = S_IDLE;
              res_d   = R_ERR;
            end else begin
              se0_d = se0_q + 2'd1;
            end
          end else if (se0_q == 2'd0) begin
            state_d = S_IDLE;
            res_d   = R_ERR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (pid_q[7:4] != ~pid_q[3:0]) begin
          res_d = R_ERR;
        end else begin
          case (pid_q)
            8'hD2:   res_d = R_ACK;
            8'h5A:   res_d = R_NAK;
            8'h1E:   res_d = R_STALL;
            8'h96:   res_d = R_NYET;
            default: res_d = R_ERR;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    case (res_d)
      R_ACK:   pulse_d[5] = 1'b1;
      R_NAK:   pulse_d[4] = 1'b1;
      R_STALL: pulse_d[3] = 1'b1;
      R_NYET:  pulse_d[2] = 1'b1;
      R_ERR:   pulse_d[1] = 1'b1;
      R_TMO:   pulse_d[0] = 1'b1;
      default: pulse_d = '0;
    endcase
    busyRx = (state_q != S_IDLE);
  end

  assign gotACK    = pulse_q[5];
  assign gotNAK    = pulse_q[4];
  assign gotSTALL  = pulse_q[3];
  assign gotNYET   = pulse_q[2];
  assign pidError  = pulse_q[1];
  assign timeoutHS = pulse_q[0];

endmodule

// File: tb/tb_handshake_rx.sv
// Directed bench for handshake_rx: a table of packets plus hand-written sequences
// for exact pulse timing, timeout, short sync, re-arm while busy and reset.
module tb_handshake_rx;

  logic useClk = 1'b0;
  logic nReset = 1'b0;
  logic checkData = 1'b0;
  logic rxBit = 1'b1;
  logic rxSE0 = 1'b0;
  logic expectHandshake = 1'b0;
  logic gotACK, gotNAK, gotSTALL, gotNYET, pidError, timeoutHS, busyRx;
  logic [5:0] pv;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_ACK  = 6'b100000;
  localparam logic [5:0] P_NAK  = 6'b010000;
  localparam logic [5:0] P_STL  = 6'b001000;
  localparam logic [5:0] P_NYT  = 6'b000100;
  localparam logic [5:0] P_ERR  = 6'b000010;
  localparam logic [5:0] P_TMO  = 6'b000001;

  handshake_rx #(.MIN_SYNC_ZEROS(4), .TIMEOUT_BITS(18)) dut (
    .useClk(useClk), .nReset(nReset), .checkData(checkData), .rxBit(rxBit),
    .rxSE0(rxSE0), .expectHandshake(expectHandshake), .gotACK(gotACK),
    .gotNAK(gotNAK), .gotSTALL(gotSTALL), .gotNYET(gotNYET),
    .pidError(pidError), .timeoutHS(timeoutHS), .busyRx(busyRx)
  );

  always #5 useClk = ~useClk;

  assign pv = {gotACK, gotNAK, gotSTALL, gotNYET, pidError, timeoutHS};

  int total = 0;
  int bad = 0;
  int npulse = 0;
  logic [5:0] first_pv = '0;

  // records the first nonzero pulse vector and how many cycles carried a pulse
  always @(negedge useClk) begin
    if (pv != 6'b0) begin
      if (npulse == 0) first_pv = pv;
      npulse = npulse + 1;
    end
  end

  typedef struct {
    logic [7:0] pid;
    int         nz;
    int         nse0;
    bit         extra;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic mon_reset();
    npulse   = 0;
    first_pv = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge useClk);
  endtask

  task automatic strobe(input logic b, input logic s);
    @(negedge useClk);
    checkData = 1'b1; rxBit = b; rxSE0 = s;
    @(negedge useClk);
    checkData = 1'b0; rxBit = 1'b1; rxSE0 = 1'b0;
  endtask

  task automatic arm();
    @(negedge useClk);
    expectHandshake = 1'b1;
    @(negedge useClk);
    expectHandshake = 1'b0;
  endtask

  task automatic sync(input int nz);
    for (int i = 0; i < nz; i++) strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
  endtask

  task automatic pid_bits(input logic [7:0] p, input int from, input int to);
    for (int i = from; i < to; i++) strobe(p[i], 1'b0);
  endtask

  task automatic send_packet(input logic [7:0] p, input int nz, input int nse0, input bit extra);
    arm();
    sync(nz);
    pid_bits(p, 0, 8);
    if (extra) strobe(1'b0, 1'b0);
    for (int i = 0; i < nse0; i++) strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 5, 2, 1'b0, P_NAK};
    vecs[1] = '{8'hD2, 5, 2, 1'b0, P_ACK};
    vecs[2] = '{8'h5B, 5, 2, 1'b0, P_ERR};
    vecs[3] = '{8'h1E, 5, 1, 1'b0, P_STL};
    vecs[4] = '{8'h96, 5, 3, 1'b0, P_NYT};
    vecs[5] = '{8'hD2, 5, 4, 1'b0, P_ERR};
    vecs[6] = '{8'hE1, 5, 2, 1'b0, P_ERR};
    vecs[7] = '{8'h5A, 5, 2, 1'b1, P_ERR};
    vecs[8] = '{8'hD2, 4, 2, 1'b0, P_ACK};

    idle(3);
    check("reset_outputs", {26'b0, pv}, {26'b0, P_NONE});
    check("reset_busy", {31'b0, busyRx}, 32'd0);
    nReset = 1'b1;
    idle(2);

    // exact timing of a NAK: DONE, then pulse with busy low, then quiet
    mon_reset();
    arm();
    check("armed_busy", {31'b0, busyRx}, 32'd1);
    sync(5);
    pid_bits(8'h5A, 0, 8);
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    check("nak_done_quiet", {26'b0, pv}, {26'b0, P_NONE});
    check("nak_done_busy", {31'b0, busyRx}, 32'd1);
    @(negedge useClk);
    check("nak_pulse", {26'b0, pv}, {26'b0, P_NAK});
    check("nak_pulse_busy", {31'b0, busyRx}, 32'd0);
    @(negedge useClk);
    check("nak_after", {26'b0, pv}, {26'b0, P_NONE});
    check("nak_after_busy", {31'b0, busyRx}, 32'd0);
    check("nak_width", npulse, 32'd1);

    for (int v = 0; v < 9; v++) begin
      mon_reset();
      send_packet(vecs[v].pid, vecs[v].nz, vecs[v].nse0, vecs[v].extra);
      check($sformatf("vec%0d_result", v), {26'b0, first_pv}, {26'b0, vecs[v].exp});
      check($sformatf("vec%0d_pulses", v), npulse, 32'd1);
      check($sformatf("vec%0d_idle", v), {31'b0, busyRx}, 32'd0);
    end

    // timeout: 18 non-zero strobes
    mon_reset();
    arm();
    for (int i = 0; i < 18; i++) strobe(1'b1, 1'b0);
    check("tmo_not_yet", {26'b0, pv}, {26'b0, P_NONE});
    check("tmo_busy_before", {31'b0, busyRx}, 32'd1);
    @(negedge useClk);
    check("tmo_pulse", {26'b0, pv}, {26'b0, P_TMO});
    check("tmo_idle", {31'b0, busyRx}, 32'd0);
    @(negedge useClk);
    check("tmo_after", {26'b0, pv}, {26'b0, P_NONE});

    // 17 idle strobes is still in time
    mon_reset();
    arm();
    for (int i = 0; i < 17; i++) strobe(1'b1, 1'b0);
    sync(5);
    pid_bits(8'hD2, 0, 8);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3);
    check("tmo17_ack", {26'b0, first_pv}, {26'b0, P_ACK});

    // zero strobe coincident with expiry is dropped
    mon_reset();
    arm();
    for (int i = 0; i < 17; i++) strobe(1'b1, 1'b0);
    @(negedge useClk);
    checkData = 1'b1; rxBit = 1'b1;
    @(negedge useClk);
    rxBit = 1'b0;
    @(negedge useClk);
    checkData = 1'b0; rxBit = 1'b1;
    check("tmo_prio_idle", {31'b0, busyRx}, 32'd0);
    idle(2);
    check("tmo_prio_pulse", {26'b0, first_pv}, {26'b0, P_TMO});

    // re-arm in WAIT must not restart the timeout count
    mon_reset();
    arm();
    for (int i = 0; i < 10; i++) strobe(1'b1, 1'b0);
    arm();
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0);
    idle(2);
    check("rearm_tmo", {26'b0, first_pv}, {26'b0, P_TMO});

    // re-arm mid-PID is ignored
    mon_reset();
    arm();
    sync(5);
    pid_bits(8'hD2, 0, 4);
    arm();
    pid_bits(8'hD2, 4, 8);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3);
    check("rearm_pid_ack", {26'b0, first_pv}, {26'b0, P_ACK});

    // 3 sync zeros then a one falls back to WAIT, later proper sync is accepted
    mon_reset();
    arm();
    sync(3);
    check("short_sync_busy", {31'b0, busyRx}, 32'd1);
    sync(5);
    pid_bits(8'h1E, 0, 8);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3);
    check("short_sync_stall", {26'b0, first_pv}, {26'b0, P_STL});

    // SE0 on a PID bit
    mon_reset();
    arm();
    sync(5);
    pid_bits(8'hD2, 0, 3);
    strobe(1'b0, 1'b1);
    check("pid_se0_err", {26'b0, pv}, {26'b0, P_ERR});
    idle(2);
    check("pid_se0_once", npulse, 32'd1);

    // reset mid-PID, then a clean ACK
    arm();
    sync(5);
    pid_bits(8'hD2, 0, 4);
    @(negedge useClk);
    nReset = 1'b0;
    @(negedge useClk);
    check("rst_mid_out", {26'b0, pv}, {26'b0, P_NONE});
    check("rst_mid_busy", {31'b0, busyRx}, 32'd0);
    nReset = 1'b1;
    mon_reset();
    send_packet(8'hD2, 5, 2, 1'b0);
    check("rst_then_ack", {26'b0, first_pv}, {26'b0, P_ACK});
    check("rst_then_once", npulse, 32'd1);

    // reset while in DONE kills the pulse in flight
    arm();
    sync(5);
    pid_bits(8'h96, 0, 8);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    nReset = 1'b0;
    mon_reset();
    @(negedge useClk);
    check("rst_flight_out", {26'b0, pv}, {26'b0, P_NONE});
    nReset = 1'b1;
    idle(3);
    check("rst_flight_none", npulse, 32'd0);
    check("rst_flight_busy", {31'b0, busyRx}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
